// File: rtl/triangle_channel_if.sv
// +----------------------------------------------------------------------+
// | Module     : triangle_channel_if                                     |
// | Description: CPU register-write bus into the APU triangle channel.   |
// |              The master drives a one-cycle write strobe together     |
// |              with a 2-bit register select and 8-bit write data.      |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

interface triangle_channel_if;
  logic       reg_we;
  logic [1:0] reg_addr;
  logic [7:0] reg_wdata;

  modport master (output reg_we, reg_addr, reg_wdata);
  modport slave  (input  reg_we, reg_addr, reg_wdata);
endinterface

`default_nettype wire

// File: rtl/triangle_channel.sv
// +----------------------------------------------------------------------+
// | Module     : triangle_channel                                        |
// | Description: NES APU triangle-wave channel. Decodes $4008/$400A/     |
// |              $400B writes and runs the 11-bit timer, 7-bit linear    |
// |              counter, 5-bit length counter and 32-step sequencer     |
// |              that produces the 4-bit amplitude for the mixer.        |
// |              Optional feature macro: TRI_ULTRASONIC_MUTE_EN - when   |
// |              defined, the sequencer does not advance while the       |
// |              timer period is below 2.                                |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module triangle_channel (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_clk_en,
  input  logic                     quarter_frame,
  input  logic                     half_frame,
  triangle_channel_if.slave        bus,
  input  logic                     chan_en,
  output logic [3:0]               tr_out,
  output logic                     length_active
);

  localparam logic [1:0] C_ADDR_4008 = 2'd0;
  localparam logic [1:0] C_ADDR_400A = 2'd2;
  localparam logic [1:0] C_ADDR_400B = 2'd3;

  // Length-counter load table, indexed by $400B bits [7:3].
  function automatic logic [7:0] len_lookup(input logic [4:0] idx);
    logic [7:0] val;
    case (idx)
      5'd0:  val = 8'd10;   5'd1:  val = 8'd254;
      5'd2:  val = 8'd20;   5'd3:  val = 8'd2;
      5'd4:  val = 8'd40;   5'd5:  val = 8'd4;
      5'd6:  val = 8'd80;   5'd7:  val = 8'd6;
      5'd8:  val = 8'd160;  5'd9:  val = 8'd8;
      5'd10: val = 8'd60;   5'd11: val = 8'd10;
      5'd12: val = 8'd14;   5'd13: val = 8'd12;
      5'd14: val = 8'd26;   5'd15: val = 8'd14;
      5'd16: val = 8'd12;   5'd17: val = 8'd16;
      5'd18: val = 8'd24;   5'd19: val = 8'd18;
      5'd20: val = 8'd48;   5'd21: val = 8'd20;
      5'd22: val = 8'd96;   5'd23: val = 8'd22;
      5'd24: val = 8'd192;  5'd25: val = 8'd24;
      5'd26: val = 8'd72;   5'd27: val = 8'd26;
      5'd28: val = 8'd16;   5'd29: val = 8'd28;
      5'd30: val = 8'd32;   default: val = 8'd30;
    endcase
    return val;
  endfunction

  logic        r_ctrl;
  logic [6:0]  r_lin_reload_val;
  logic        r_lin_reload_flag;
  logic [10:0] r_period;
  logic [10:0] r_timer;
  logic [4:0]  r_step;
  logic [6:0]  r_linear;
  logic [7:0]  r_length;

  logic w_wr_4008;
  logic w_wr_400a;
  logic w_wr_400b;
  logic w_counters_live;
  logic w_step_allow;

  assign w_wr_4008 = bus.reg_we && (bus.reg_addr == C_ADDR_4008);
  assign w_wr_400a = bus.reg_we && (bus.reg_addr == C_ADDR_400A);
  assign w_wr_400b = bus.reg_we && (bus.reg_addr == C_ADDR_400B);

  assign w_counters_live = (r_linear != 7'd0) && (r_length != 8'd0);

`ifdef TRI_ULTRASONIC_MUTE_EN
  // Very short periods produce inaudible ultrasonic output that pops
  // when it stops; hold the sequencer instead.
  assign w_step_allow = w_counters_live && (r_period >= 11'd2);
`else
  assign w_step_allow = w_counters_live;
`endif

  // CPU-visible control and period registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl           <= 1'b0;
      r_lin_reload_val <= 7'd0;
      r_period         <= 11'd0;
    end else begin
      if (w_wr_4008) begin
        r_ctrl           <= bus.reg_wdata[7];
        r_lin_reload_val <= bus.reg_wdata[6:0];
      end
      if (w_wr_400a) begin
        r_period[7:0] <= bus.reg_wdata;
      end
      if (w_wr_400b) begin
        r_period[10:8] <= bus.reg_wdata[2:0];
      end
    end
  end

  // Timer counts down per CPU tick; each expiry reloads it and may advance the step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= 11'd0;
      r_step  <= 5'd0;
    end else if (cpu_clk_en) begin
      if (r_timer == 11'd0) begin
        r_timer <= r_period;
        if (w_step_allow) begin
          r_step <= r_step + 5'd1;
        end
      end else begin
        r_timer <= r_timer - 11'd1;
      end
    end
  end

  // Linear counter on quarter-frame; the reload flag is set by $400B and
  // that set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_linear          <= 7'd0;
      r_lin_reload_flag <= 1'b0;
    end else begin
      if (quarter_frame) begin
        if (r_lin_reload_flag) begin
          r_linear <= r_lin_reload_val;
        end else if (r_linear != 7'd0) begin
          r_linear <= r_linear - 7'd1;
        end
      end
      if (w_wr_400b) begin
        r_lin_reload_flag <= 1'b1;
      end else if (quarter_frame && !r_ctrl) begin
        r_lin_reload_flag <= 1'b0;
      end
    end
  end

  // Length counter: disable clears it, a $400B load beats a half-frame decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_length <= 8'd0;
    end else if (!chan_en) begin
      r_length <= 8'd0;
    end else if (w_wr_400b) begin
      r_length <= len_lookup(bus.reg_wdata[7:3]);
    end else if (half_frame && !r_ctrl && (r_length != 8'd0)) begin
      r_length <= r_length - 8'd1;
    end
  end

  // Step 0..15 descends, 16..31 ascends; the output holds whenever the step is frozen.
  assign tr_out        = r_step[4] ? r_step[3:0] : ~r_step[3:0];
  assign length_active = (r_length != 8'd0);

endmodule

`default_nettype wire

// File: tb/tb_triangle_channel.sv
// +----------------------------------------------------------------------+
// | Module     : tb_triangle_channel                                     |
// | Description: Directed bench for triangle_channel: a vector table of  |
// |              per-cycle inputs with hand-computed outputs, plus       |
// |              sequences for reset, the full waveform and the          |
// |              TRI_ULTRASONIC_MUTE_EN behaviour.                       |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_triangle_channel;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [1:0] A8 = 2'd0;
  localparam logic [1:0] AA = 2'd2;
  localparam logic [1:0] AB = 2'd3;
  localparam int NV = 54;

  typedef struct {
    logic       ce;
    logic       qf;
    logic       hf;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wd;
    logic       en;
    logic [3:0] tr;
    logic       la;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_clk_en;
  logic       quarter_frame;
  logic       half_frame;
  logic       chan_en;
  logic [3:0] tr_out;
  logic       length_active;

  triangle_channel_if bus ();

  triangle_channel dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_clk_en    (cpu_clk_en),
    .quarter_frame (quarter_frame),
    .half_frame    (half_frame),
    .bus           (bus.slave),
    .chan_en       (chan_en),
    .tr_out        (tr_out),
    .length_active (length_active)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  vec_t vecs [NV];
  logic [3:0] exp_wave [32] = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8,
                                4'd7,  4'd6,  4'd5,  4'd4,  4'd3,  4'd2,  4'd1, 4'd0,
                                4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6, 4'd7,
                                4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};

  task automatic check(input string name, input logic [3:0] tr_exp, input logic la_exp);
    n_total++;
    if (tr_out === tr_exp && length_active === la_exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: tr_out=%0d length_active=%0b, expected tr_out=%0d length_active=%0b",
               name, tr_out, length_active, tr_exp, la_exp);
    end
  endtask

  // Drive one clk cycle of inputs, then sample 1 time unit after the edge.
  task automatic apply(input logic ce, input logic qf, input logic hf, input logic we,
                       input logic [1:0] a, input logic [7:0] d, input logic en);
    cpu_clk_en    = ce;
    quarter_frame = qf;
    half_frame    = hf;
    bus.reg_we    = we;
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    chan_en       = en;
    @(posedge clk);
    #1;
    cpu_clk_en    = 1'b0;
    quarter_frame = 1'b0;
    half_frame    = 1'b0;
    bus.reg_we    = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    apply(N, N, N, Y, a, d, Y);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic ce, input logic qf, input logic hf, input logic we,
                              input logic [1:0] a, input logic [7:0] d, input logic en,
                              input logic [3:0] tr, input logic la);
    vec_t v;
    v.ce = ce; v.qf = qf; v.hf = hf; v.we = we; v.addr = a; v.wd = d;
    v.en = en; v.tr = tr; v.la = la;
    return v;
  endfunction

  initial begin
    // Period 2 (3 ticks per step); $400B=0x18 loads length 2.
    vecs[0]  = mk(N,N,N,Y,A8,8'h05,Y,4'd15,N);
    vecs[1]  = mk(N,N,N,Y,AA,8'h02,Y,4'd15,N);
    vecs[2]  = mk(N,N,N,Y,AB,8'h18,Y,4'd15,Y);
    vecs[3]  = mk(N,Y,N,N,A8,8'h00,Y,4'd15,Y);
    vecs[4]  = mk(Y,N,N,N,A8,8'h00,Y,4'd14,Y);
    vecs[5]  = mk(Y,N,N,N,A8,8'h00,Y,4'd14,Y);
    vecs[6]  = mk(Y,N,N,N,A8,8'h00,Y,4'd14,Y);
    vecs[7]  = mk(Y,N,N,N,A8,8'h00,Y,4'd13,Y);
    vecs[8]  = mk(N,N,Y,N,A8,8'h00,Y,4'd13,Y);
    vecs[9]  = mk(N,N,Y,N,A8,8'h00,Y,4'd13,N);
    vecs[10] = mk(Y,N,N,N,A8,8'h00,Y,4'd13,N);
    vecs[11] = mk(Y,N,N,N,A8,8'h00,Y,4'd13,N);
    vecs[12] = mk(Y,N,N,N,A8,8'h00,Y,4'd13,N);
    // Halt set: half-frames leave length at 2.
    vecs[13] = mk(N,N,N,Y,A8,8'h85,Y,4'd13,N);
    vecs[14] = mk(N,N,N,Y,AB,8'h18,Y,4'd13,Y);
    vecs[15] = mk(N,N,Y,N,A8,8'h00,Y,4'd13,Y);
    vecs[16] = mk(N,N,Y,N,A8,8'h00,Y,4'd13,Y);
    vecs[17] = mk(Y,N,N,N,A8,8'h00,Y,4'd13,Y);
    vecs[18] = mk(Y,N,N,N,A8,8'h00,Y,4'd13,Y);
    vecs[19] = mk(Y,N,N,N,A8,8'h00,Y,4'd12,Y);
    // Channel disable clears length and blocks loads.
    vecs[20] = mk(N,N,N,N,A8,8'h00,N,4'd12,N);
    vecs[21] = mk(N,N,N,Y,AB,8'h18,N,4'd12,N);
    vecs[22] = mk(N,N,N,N,A8,8'h00,Y,4'd12,N);
    // $400B load coincident with half_frame: exactly 2, then 1, then 0.
    vecs[23] = mk(N,N,N,Y,A8,8'h05,Y,4'd12,N);
    vecs[24] = mk(N,N,Y,Y,AB,8'h18,Y,4'd12,Y);
    vecs[25] = mk(N,N,Y,N,A8,8'h00,Y,4'd12,Y);
    vecs[26] = mk(N,N,Y,N,A8,8'h00,Y,4'd12,N);
    // Linear 3,2,1 then one step, then 0 freezes the sequencer.
    vecs[27] = mk(N,N,N,Y,A8,8'h03,Y,4'd12,N);
    vecs[28] = mk(N,N,N,Y,AB,8'h18,Y,4'd12,Y);
    vecs[29] = mk(N,Y,N,N,A8,8'h00,Y,4'd12,Y);
    vecs[30] = mk(N,Y,N,N,A8,8'h00,Y,4'd12,Y);
    vecs[31] = mk(N,Y,N,N,A8,8'h00,Y,4'd12,Y);
    vecs[32] = mk(Y,N,N,N,A8,8'h00,Y,4'd12,Y);
    vecs[33] = mk(Y,N,N,N,A8,8'h00,Y,4'd12,Y);
    vecs[34] = mk(Y,N,N,N,A8,8'h00,Y,4'd11,Y);
    vecs[35] = mk(N,Y,N,N,A8,8'h00,Y,4'd11,Y);
    vecs[36] = mk(Y,N,N,N,A8,8'h00,Y,4'd11,Y);
    vecs[37] = mk(Y,N,N,N,A8,8'h00,Y,4'd11,Y);
    vecs[38] = mk(Y,N,N,N,A8,8'h00,Y,4'd11,Y);
    // $400B with quarter_frame: flag ends set, so the next pulse reloads 3.
    vecs[39] = mk(N,Y,N,Y,AB,8'h18,Y,4'd11,Y);
    vecs[40] = mk(N,Y,N,N,A8,8'h00,Y,4'd11,Y);
    vecs[41] = mk(Y,N,N,N,A8,8'h00,Y,4'd11,Y);
    vecs[42] = mk(Y,N,N,N,A8,8'h00,Y,4'd11,Y);
    vecs[43] = mk(Y,N,N,N,A8,8'h00,Y,4'd10,Y);
    // Control set: linear reloads to 3 on every quarter-frame.
    vecs[44] = mk(N,N,N,Y,A8,8'h83,Y,4'd10,Y);
    vecs[45] = mk(N,Y,N,N,A8,8'h00,Y,4'd10,Y);
    vecs[46] = mk(N,N,N,Y,AB,8'h18,Y,4'd10,Y);
    vecs[47] = mk(N,Y,N,N,A8,8'h00,Y,4'd10,Y);
    vecs[48] = mk(N,Y,N,N,A8,8'h00,Y,4'd10,Y);
    vecs[49] = mk(N,Y,N,N,A8,8'h00,Y,4'd10,Y);
    vecs[50] = mk(N,Y,N,N,A8,8'h00,Y,4'd10,Y);
    vecs[51] = mk(Y,N,N,N,A8,8'h00,Y,4'd10,Y);
    vecs[52] = mk(Y,N,N,N,A8,8'h00,Y,4'd10,Y);
    vecs[53] = mk(Y,N,N,N,A8,8'h00,Y,4'd9,Y);

    cpu_clk_en    = 1'b0;
    quarter_frame = 1'b0;
    half_frame    = 1'b0;
    bus.reg_we    = 1'b0;
    bus.reg_addr  = 2'd0;
    bus.reg_wdata = 8'h00;
    chan_en       = 1'b1;
    rst_n         = 1'b0;

    #2;
    check("reset_state", 4'd15, 1'b0);
    do_reset();
    apply(N, N, N, N, A8, 8'h00, Y);
    check("after_release", 4'd15, 1'b0);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].ce, vecs[i].qf, vecs[i].hf, vecs[i].we,
            vecs[i].addr, vecs[i].wd, vecs[i].en);
      check($sformatf("vec%0d", i), vecs[i].tr, vecs[i].la);
    end

    // Asynchronous reset mid-run, observed before the next clock edge.
    #3;
    rst_n = 1'b0;
    #2;
    check("async_reset", 4'd15, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      apply(Y, N, N, N, A8, 8'h00, Y);
      check($sformatf("idle_after_reset%0d", t), 4'd15, 1'b0);
    end

    // Full waveform: period 3, one step every 4 ticks, length 254.
    do_reset();
    wr(A8, 8'h81);
    wr(AA, 8'h03);
    wr(AB, 8'h08);
    apply(N, Y, N, N, A8, 8'h00, Y);
    check("wave_start", 4'd15, 1'b1);
    for (int t = 1; t <= 132; t++) begin
      apply(Y, N, N, N, A8, 8'h00, Y);
      check($sformatf("wave_t%0d", t), exp_wave[((t + 3) / 4) % 32], 1'b1);
    end

    // Period 1: advances every 2 ticks, or holds when the mute feature is built in.
    do_reset();
    wr(A8, 8'h81);
    wr(AA, 8'h01);
    wr(AB, 8'h08);
    apply(N, Y, N, N, A8, 8'h00, Y);
    for (int t = 1; t <= 8; t++) begin
      apply(Y, N, N, N, A8, 8'h00, Y);
`ifdef TRI_ULTRASONIC_MUTE_EN
      check($sformatf("short_period_t%0d", t), 4'd15, 1'b1);
`else
      check($sformatf("short_period_t%0d", t), exp_wave[(t + 1) / 2], 1'b1);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/triangle_channel.md
# triangle_channel

NES APU triangle-wave channel: CPU register decode for $4008/$400A/$400B, 11-bit timer, 7-bit linear counter, 5-bit length counter and 32-step sequencer. Produces the 4-bit `tr_out` consumed by the nonlinear mixer, where it enters the TND lookup index as `3 * tr_out`. Sits upstream of the mixer, alongside the square, noise and DMC channels, and is driven by the frame sequencer's quarter/half-frame strobes.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: system clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_clk_en` in 1: one-`clk` pulse per CPU cycle; triangle timer tick.
- `quarter_frame` in 1: one-cycle pulse from the frame sequencer; clocks the linear counter.
- `half_frame` in 1: one-cycle pulse; clocks the length counter.
- `reg_we` in 1: register write strobe; one `clk` cycle per write.
- `reg_addr` in 2: 0 = $4008, 2 = $400A, 3 = $400B; 1 is ignored.
- `reg_wdata` in 8: write data.
- `chan_en` in 1: $4015 bit 2 (channel enable).
- `tr_out` out 4: channel amplitude, 0..15.
- `length_active` out 1: length counter != 0; feeds the $4015 read.

## Operation
- $4008 write: `ctrl <= wdata[7]` (length halt / linear control); `lin_reload_val <= wdata[6:0]`.
- $400A write: `period[7:0] <= wdata`.
- $400B write:
  - `period[10:8] <= wdata[2:0]`.
  - `lin_reload_flag <= 1`.
  - If `chan_en`, `length <= LEN_TBL[wdata[7:3]]`.
  - `LEN_TBL` = 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.
- Timer (on `cpu_clk_en`):
  - If `timer == 0`: `timer <= period`, and `step <= step + 1` (5-bit, wraps 31→0) when `linear != 0 && length != 0`.
  - Else: `timer <= timer - 1`.
- Linear counter (on `quarter_frame`):
  - If `lin_reload_flag`: `linear <= lin_reload_val`.
  - Else if `linear != 0`: `linear <= linear - 1`.
  - Then, if `ctrl == 0`: `lin_reload_flag <= 0`.
- Length counter (on `half_frame`): if `ctrl == 0 && length != 0`, `length <= length - 1`.
- `chan_en == 0` forces `length <= 0` every cycle and blocks loads.
- Output decode (combinational from `step`): `tr_out = step[4] ? step[3:0] : ~step[3:0]`, giving the sequence 15..0, 0..15.
- Silencing: when `linear` or `length` is 0 the sequencer freezes and `tr_out` holds its last value. There is no forced zero.

## Timing
- Reset values: all outputs and state 0, including `timer`, `period`, `step`, `linear`, `length`, `ctrl` and `lin_reload_flag`. Hence `tr_out = 15` and `length_active = 0`.
- Register writes take effect at the same edge that samples `reg_we`.
- `tr_out` changes on the edge where `cpu_clk_en` is high and `timer == 0` with both counters nonzero. There is zero added latency beyond that edge.
- Step period is `period + 1` CPU ticks.
- Simultaneous $400B write and `half_frame`: the write wins; the length is loaded with no decrement that cycle.
- Simultaneous $400B write and `quarter_frame`:
  - The linear counter uses the pre-write flag value.
  - The flag ends set, because the write has priority over the clear.
- $400A/$400B writes do not reload `timer`; the new period is used at the next reload.
- `rst_n` assertion mid-operation clears all state immediately (asynchronous).
- Deassertion takes effect at the next `clk` edge.

## Configuration
- `TRI_ULTRASONIC_MUTE_EN`:
  - Defined: when `period < 2`, the sequencer does not advance, so `tr_out` holds. This suppresses ultrasonic popping.
  - Undefined: the sequencer advances for any period, matching hardware.

## Test plan
- Reset: assert `rst_n = 0` mid-run → `tr_out = 15`, `length_active = 0`. After release with no writes → `tr_out` stays 15.
- Waveform:
  - Stimulus: $4008=0x81, $400A=0x03, $400B=0x08 (`chan_en = 1`), one `quarter_frame`, `cpu_clk_en` every cycle.
  - Response: `tr_out` steps 15,14,…,0,0,1,…,15 once every 4 ticks; `length_active = 1` with length = 254.
- Length:
  - Stimulus: $4008=0x05, $400B=0x18 (length 2), then two `half_frame` pulses.
  - Response: `length_active` drops after the second pulse and `tr_out` freezes.
  - Repeat with $4008=0x85 → length stays at 2.
- Linear:
  - Stimulus: $4008=0x03, $400B write, four `quarter_frame` pulses.
  - Response: linear goes 3,2,1,0 and the sequencer freezes after the 4th pulse.
  - With ctrl=1 → linear reloads to 3 on every pulse.
- Enable and priority:
  - `chan_en = 0` → `length_active = 0` immediately, and $400B writes load nothing.
  - $400B write coincident with `half_frame` → `length` equals the table value exactly.
- Macro: with the macro defined, $400A=0x01, $400B=0x08 → `tr_out` never changes. Undefined → it advances every 2 ticks.
